// File: rtl/led_status_ctrl_if.sv
// Signal bundle for the status LED output stage: fader/activity/error inputs, LED drive and busy.
// Every signal is level- or strobe-sampled on each rising clock edge; there is no valid/ready handshake.
interface led_status_ctrl_if #(
    parameter int MXCODE = 4
);
    logic              fader_led;
    logic              activity;
    logic [MXCODE-1:0] err_code;
    logic              led;
    logic              busy;
    logic [1:0]        fsm_state;

    modport master (
        output fader_led,
        output activity,
        output err_code,
        input  led,
        input  busy,
        input  fsm_state
    );

    modport slave (
        input  fader_led,
        input  activity,
        input  err_code,
        output led,
        output busy,
        output fsm_state
    );
endinterface

// File: rtl/led_status_ctrl.sv
// Final LED drive: error blink codes override stretched activity flashes, which override fader breathing.
// The activity stretcher is built only when LED_ACTIVITY_EN is defined.
module led_status_ctrl #(
    parameter int MXCODE         = 4,
    parameter int BLINK_CYCLES   = 2**22,
    parameter int GAP_CYCLES     = 2**24,
    parameter int STRETCH_CYCLES = 2**21
) (
    input  logic             clock,
    input  logic             reset_n,
    led_status_ctrl_if.slave bus
);
    localparam int PHASE_MAX = (BLINK_CYCLES > GAP_CYCLES) ? BLINK_CYCLES : GAP_CYCLES;
    localparam int CW        = $clog2(PHASE_MAX + 1);

    localparam logic [CW-1:0] BLINK_RELOAD = CW'(BLINK_CYCLES - 1);
    localparam logic [CW-1:0] GAP_RELOAD   = CW'(GAP_CYCLES - 1);

    if (BLINK_CYCLES < 1) begin : g_bad_blink
        $error("BLINK_CYCLES must be at least 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("GAP_CYCLES must be at least 1");
    end
    if (STRETCH_CYCLES < 1) begin : g_bad_stretch
        $error("STRETCH_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_n;
    logic [MXCODE-1:0] left;
    logic [MXCODE-1:0] left_n;
    logic              led_q;
    logic              led_n;
    logic              busy_q;
    logic              busy_n;
    logic              stretch_on;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            left   <= '0;
            led_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            left   <= left_n;
            led_q  <= led_n;
            busy_q <= busy_n;
        end
    end

    // err_code is only looked at in IDLE, so a code change mid-sequence waits for the next pass.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        left_n  = left;
        unique case (state)
            ST_IDLE: begin
                if (bus.err_code != '0) begin
                    state_n = ST_ON;
                    left_n  = bus.err_code;
                    cnt_n   = BLINK_RELOAD;
                end
            end
            ST_ON: begin
                if (cnt == '0) begin
                    state_n = ST_OFF;
                    cnt_n   = BLINK_RELOAD;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ST_OFF: begin
                if (cnt == '0) begin
                    left_n = left - MXCODE'(1);
                    if (left > MXCODE'(1)) begin
                        state_n = ST_ON;
                        cnt_n   = BLINK_RELOAD;
                    end else begin
                        state_n = ST_GAP;
                        cnt_n   = GAP_RELOAD;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
                left_n  = '0;
            end
        endcase
    end

    always_comb begin
        led_n  = 1'b0;
        busy_n = (state != ST_IDLE);
        unique case (state)
            ST_ON:   led_n = 1'b1;
            ST_IDLE: led_n = stretch_on ? 1'b1 : bus.fader_led;
            default: led_n = 1'b0;
        endcase
    end

`ifdef LED_ACTIVITY_EN
    localparam int SW = $clog2(STRETCH_CYCLES + 1);

    logic [SW-1:0] scnt;

    // Runs in every FSM state so a flash caught during an error code still shows afterwards.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scnt <= '0;
        end else if (bus.activity) begin
            scnt <= SW'(STRETCH_CYCLES);
        end else if (scnt != '0) begin
            scnt <= scnt - SW'(1);
        end
    end

    assign stretch_on = (scnt != '0);
`else
    logic unused_activity;

    assign unused_activity = bus.activity;
    assign stretch_on      = 1'b0;
`endif

    assign bus.led       = led_q;
    assign bus.busy      = busy_q;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl: two instances (short and long stretch) checked every cycle
// against a sequence-position model, plus hand-computed LED/busy patterns.
module tb_led_status_ctrl;
    localparam int MX = 4;
    localparam int B  = 4;
    localparam int G  = 8;
    localparam int S0 = 5;
    localparam int S1 = 20;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic          fader   = 1'b0;
    logic          activity = 1'b0;
    logic [MX-1:0] err     = '0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    led_status_ctrl_if #(.MXCODE(MX)) bus0 ();
    led_status_ctrl_if #(.MXCODE(MX)) bus1 ();

    assign bus0.fader_led = fader;
    assign bus0.activity  = activity;
    assign bus0.err_code  = err;
    assign bus1.fader_led = fader;
    assign bus1.activity  = activity;
    assign bus1.err_code  = err;

    led_status_ctrl #(
        .MXCODE(MX), .BLINK_CYCLES(B), .GAP_CYCLES(G), .STRETCH_CYCLES(S0)
    ) u_dut0 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus0.slave)
    );

    led_status_ctrl #(
        .MXCODE(MX), .BLINK_CYCLES(B), .GAP_CYCLES(G), .STRETCH_CYCLES(S1)
    ) u_dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an error code is a run of 2*N*B + G cycles indexed by position; the stretch is
    // measured as edges elapsed since the last activity strobe.
    int   s_tab[2] = '{S0, S1};
    bit   m_in_seq[2];
    int   m_pos[2];
    int   m_n[2];
    int   m_age[2];
    int   m_rem;
    logic exp_led[2]  = '{1'b0, 1'b0};
    logic exp_busy[2] = '{1'b0, 1'b0};

    always @(posedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                m_in_seq[d] = 1'b0;
                m_pos[d]    = 0;
                m_n[d]      = 0;
                m_age[d]    = s_tab[d];
                exp_led[d]  = 1'b0;
                exp_busy[d] = 1'b0;
            end else begin
                m_rem = (m_age[d] < s_tab[d]) ? (s_tab[d] - m_age[d]) : 0;
`ifndef LED_ACTIVITY_EN
                m_rem = 0;
`endif
                if (m_in_seq[d]) begin
                    exp_busy[d] = 1'b1;
                    exp_led[d]  = (m_pos[d] < 2 * m_n[d] * B) ? (((m_pos[d] / B) % 2) == 0) : 1'b0;
                end else begin
                    exp_busy[d] = 1'b0;
                    exp_led[d]  = (m_rem != 0) ? 1'b1 : fader;
                end
                if (m_in_seq[d]) begin
                    m_pos[d]++;
                    if (m_pos[d] == 2 * m_n[d] * B + G) m_in_seq[d] = 1'b0;
                end else if (err != '0) begin
                    m_in_seq[d] = 1'b1;
                    m_pos[d]    = 0;
                    m_n[d]      = int'(err);
                end
                if (activity) m_age[d] = 0;
                else if (m_age[d] < s_tab[d]) m_age[d]++;
            end
        end
    end

    always @(negedge clock) begin
        if (!reset_n) begin
            check("rst_led0", bus0.led, 1'b0);
            check("rst_busy0", bus0.busy, 1'b0);
            check("rst_led1", bus1.led, 1'b0);
            check("rst_busy1", bus1.busy, 1'b0);
        end else begin
            check("model_led0", bus0.led, exp_led[0]);
            check("model_busy0", bus0.busy, exp_busy[0]);
            check("model_led1", bus1.led, exp_led[1]);
            check("model_busy1", bus1.busy, exp_busy[1]);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] vec;
    logic [7:0]  pat;
    int          cnt_busy;
    int          cnt_led;

    initial begin
        // reset held while every input toggles
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            fader    = ~fader;
            activity = ~activity;
            err      = err + 4'd3;
        end
        @(negedge clock);
        fader    = 1'b0;
        activity = 1'b0;
        err      = '0;
        reset_n  = 1'b1;

        // fader passthrough, one cycle of latency
        pat = 8'b1011_0010;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clock);
            if (i > 0) check("fader_pass", bus0.led, pat[i-1]);
            fader = (i < 8) ? pat[i] : 1'b0;
        end
        repeat (3) @(negedge clock);

        // one-cycle pulse of code 3
        err = 4'd3;
        @(negedge clock);
        err      = '0;
        vec      = '0;
        cnt_busy = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            vec[i]   = bus0.led;
            cnt_busy += int'(bus0.busy);
        end
        check("code3_pattern", vec, 32'h000F_0F0F);
        check("code3_busy_len", cnt_busy, 32);
        @(negedge clock);
        check("code3_busy_end", bus0.busy, 1'b0);
        repeat (4) @(negedge clock);
        check("code3_stays_idle", bus0.busy, 1'b0);

        // code held at 3, switched to 5 during the second blink
        err      = 4'd3;
        cnt_busy = 0;
        cnt_led  = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clock);
            if (i == 10) err = 4'd5;
            if (i == 40) err = '0;
            cnt_busy += int'(bus0.busy);
            cnt_led  += int'(bus0.led);
        end
        check("change_busy_total", cnt_busy, 80);
        check("change_led_total", cnt_led, 32);

        // activity retrigger: strobes sampled at edges 0 and 3
        activity = 1'b1;
        vec      = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (i == 0) activity = 1'b0;
            if (i == 2) activity = 1'b1;
            if (i == 3) activity = 1'b0;
            if (i >= 1 && i <= 10) vec[i-1] = bus0.led;
        end
`ifdef LED_ACTIVITY_EN
        check("retrigger_pattern", vec, 32'h0000_00FF);
`else
        check("retrigger_pattern", vec, 32'h0000_0000);
`endif
        repeat (25) @(negedge clock);

        // activity during blink 1 of code 1; long stretch outlives the sequence
        err = 4'd1;
        @(negedge clock);
        err      = '0;
        activity = 1'b1;
        @(negedge clock);
        activity = 1'b0;
        vec      = '0;
        for (int j = 2; j <= 24; j++) begin
            @(negedge clock);
            if (j == 16) check("act_err_busy_last", bus1.busy, 1'b1);
            if (j == 17) begin
                check("act_err_busy_done", bus1.busy, 1'b0);
                check("act_err_short_led", bus0.led, 1'b0);
            end
            if (j >= 17 && j <= 22) vec[j-17] = bus1.led;
        end
`ifdef LED_ACTIVITY_EN
        check("act_err_long_led", vec, 32'h0000_001F);
`else
        check("act_err_long_led", vec, 32'h0000_0000);
`endif
        repeat (4) @(negedge clock);

        // async reset during an ON phase, released with a code pending
        err = 4'd2;
        @(negedge clock);
        err = '0;
        @(negedge clock);
        check("on_before_rst", bus0.led, 1'b1);
        #2;
        reset_n = 1'b0;
        err     = 4'd2;
        #1;
        check("async_led0", bus0.led, 1'b0);
        check("async_busy0", bus0.busy, 1'b0);
        check("async_led1", bus1.led, 1'b0);
        check("async_busy1", bus1.busy, 1'b0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        err = '0;
        @(negedge clock);
        check("restart_busy", bus0.busy, 1'b1);
        check("restart_led", bus0.led, 1'b1);
        repeat (30) @(negedge clock);
        check("restart_done", bus0.busy, 1'b0);

        // async reset released with no code: stays idle
        #2;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n  = 1'b1;
        cnt_busy = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            cnt_busy += int'(bus0.busy);
        end
        check("no_code_idle", cnt_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/led_status_ctrl.md
# led_status_ctrl

Output stage for front-end status LEDs, downstream of the PWM breathing fader. It takes the fader's PWM bit, single-cycle activity strobes and a numeric error code, and produces the final registered LED drive. Precedence, highest first: error blink codes (N blinks then a gap), stretched activity flashes, idle fader breathing.

## Interface
Parameters:
- MXCODE, 4: width of err_code; blink count is 1 to 2^MXCODE-1.
- BLINK_CYCLES, 2**22: clock cycles per blink ON half and per OFF half; must be ≥1.
- GAP_CYCLES, 2**24: clock cycles LED held dark after the last blink of a code; must be ≥1.
- STRETCH_CYCLES, 2**21: clock cycles the LED is forced on after an activity strobe; must be ≥1.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset; assertion takes effect immediately, deassertion is sampled on clock.
- fader_led  in  1  PWM output of the fader stage.
- activity  in  1  activity strobe; every high cycle counts as a trigger.
- err_code  in  MXCODE  error code; 0 means no error.
- led  out  1  registered LED drive.
- busy  out  1  registered; high while an error sequence is in progress.

## Operation
- Error FSM states: IDLE, ON, OFF, GAP. There is one phase counter, cnt, sized $clog2(max(BLINK_CYCLES, GAP_CYCLES)+1), and a blink counter, left, of MXCODE bits.
- IDLE: if err_code ≠ 0, the next state is ON, with left ← err_code and cnt ← BLINK_CYCLES-1. If err_code = 0, the FSM stays in IDLE.
- ON: when cnt = 0, go to OFF with cnt ← BLINK_CYCLES-1. Otherwise cnt decrements.
- OFF: when cnt = 0, go to ON if left > 1, otherwise go to GAP with cnt ← GAP_CYCLES-1. In both cases left decrements and cnt is reloaded. While cnt ≠ 0, cnt decrements.
- GAP: when cnt = 0, go to IDLE. Otherwise cnt decrements.
- err_code is sampled only in IDLE. Changes during ON/OFF/GAP are ignored. If err_code is still nonzero when the FSM returns to IDLE, the new value is sampled on that next cycle and the sequence repeats.
- Activity stretcher: stretch counter scnt is sized $clog2(STRETCH_CYCLES+1).
  - activity = 1 loads scnt ← STRETCH_CYCLES; a retrigger reloads it, extending the flash.
  - When activity = 0 and scnt ≠ 0, scnt decrements.
  - The stretcher runs in every FSM state, including during error sequences.
- Output selection, computed from the current registers and registered into led:
  - ON gives 1.
  - OFF or GAP gives 0.
  - IDLE with scnt ≠ 0 gives 1.
  - IDLE with scnt = 0 gives fader_led.
- busy is registered as (state ≠ IDLE).
- fader_led is treated as synchronous to clock. No synchronizer is used.

## Timing
- During reset: state = IDLE, cnt = 0, left = 0, scnt = 0, led = 0, busy = 0. All of these apply asynchronously on reset_n falling.
- First active edge after reset_n rises: normal operation begins. A reset in the middle of a sequence aborts it with no resume.
- Let edge k be the edge where IDLE samples err_code = N ≠ 0:
  - state = ON after edge k.
  - led = 1 and busy = 1 from edge k+1.
- Per blink, led is high for BLINK_CYCLES cycles and then low for BLINK_CYCLES cycles.
- Sequence length is N·2·BLINK_CYCLES + GAP_CYCLES cycles. busy is high for exactly that count.
- After the sequence, led returns to activity/fader selection on the edge after state re-enters IDLE.
- Activity strobe at edge j, with the FSM in IDLE: led = 1 from edge j+1 for STRETCH_CYCLES cycles.
- Fader passthrough latency is 1 cycle.
- Simultaneous events:
  - Activity and a new error code in the same cycle: the error wins the output, and scnt still loads.
  - If scnt ≠ 0 when the error sequence ends, led is 1 until scnt expires.

## Configuration
- LED_ACTIVITY_EN defined: the activity stretcher is built as above.
- LED_ACTIVITY_EN undefined: scnt logic is omitted and the activity port is unused.
  - In IDLE, led = fader_led with 1-cycle latency.
  - The error FSM is unchanged.

## Test plan
Bench parameters: BLINK_CYCLES=4, GAP_CYCLES=8, STRETCH_CYCLES=5, LED_ACTIVITY_EN defined. fader_led=0 except in the passthrough scenario.
- Reset: hold reset_n=0 while toggling all inputs → led=0 and busy=0 throughout. After release with err_code=0 and fader_led toggling, led follows fader_led delayed 1 cycle.
- Error code: pulse err_code=3 for one cycle → led pattern 4 high/4 low ×3, then 8 low. busy high for exactly 32 cycles. The FSM then stays in IDLE.
- Code change: hold err_code=3 and change it to 5 during the second blink → three blinks, 8-cycle gap, then five blinks.
- Activity retrigger: activity at cycle 0 and again at cycle 3 → led high for cycles 1–8, low from cycle 9.
- Activity during error: activity strobe during blink 1 of err_code=1, STRETCH_CYCLES=20 → led high after the gap until scnt expires, then fader_led.
- Async reset: drop reset_n during an ON phase → led=0 and busy=0 with no clock edge. After release, the sequence restarts from IDLE only if err_code ≠ 0.
